// File: rtl/stack_ctrl_if.sv
// CPU-side request/response and stack-side strobe bundle for stack_ctrl.
// master = the controller, slave = the CPU/stack environment.
interface stack_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             call_req;
    logic             ret_req;
    logic [WIDTH-1:0] pc_in;
    logic [WIDTH-1:0] ret_addr;
    logic             busy;
    logic             done;
    logic             err;
    logic             stk_push;
    logic             stk_pop;
    logic [WIDTH-1:0] stk_wdata;
    logic [WIDTH-1:0] stk_rdata;
    logic             stk_empty;
    logic             stk_full;

    modport master (
        input  call_req, ret_req, pc_in, stk_rdata, stk_empty, stk_full,
        output ret_addr, busy, done, err, stk_push, stk_pop, stk_wdata
    );

    modport slave (
        output call_req, ret_req, pc_in, stk_rdata, stk_empty, stk_full,
        input  ret_addr, busy, done, err, stk_push, stk_pop, stk_wdata
    );
endinterface

// File: rtl/stack_ctrl.sv
// Call/return controller sequencing push/pop strobes to an external return-address stack.
// Define STACK_CTRL_STICKY_ERR_EN to make err hold from the first failing DONE until rst.
module stack_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    stack_ctrl_if.master  bus
);

    typedef enum logic [2:0] {StIdle, StPush, StPop, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] ret_addr_q, ret_addr_d;
    logic             err_q, err_d;
    logic             fail;

    always_comb begin
        state_d    = state_q;
        wdata_d    = wdata_q;
        ret_addr_d = ret_addr_q;
        fail       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.call_req && bus.ret_req) begin
                    state_d = StDone;
                    fail    = 1'b1;
                end else if (bus.call_req) begin
                    if (bus.stk_full) begin
                        state_d = StDone;
                        fail    = 1'b1;
                    end else begin
                        state_d = StPush;
                        wdata_d = bus.pc_in + 1'b1;
                    end
                end else if (bus.ret_req) begin
                    if (bus.stk_empty) begin
                        state_d = StDone;
                        fail    = 1'b1;
                    end else begin
                        state_d = StPop;
                    end
                end
            end
            StPush: state_d = StDone;
            StPop:  state_d = StWait;
            StWait: begin
                // Stack read data is valid in the cycle after the pop edge.
                ret_addr_d = bus.stk_rdata;
                state_d    = StDone;
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef STACK_CTRL_STICKY_ERR_EN
    assign err_d   = err_q | fail;
    assign bus.err = err_q;
`else
    // Error status of the current transaction, latched on leaving IDLE.
    assign err_d   = (state_q == StIdle) ? fail : err_q;
    assign bus.err = err_q && (state_q == StDone);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wdata_q    <= '0;
            ret_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wdata_q    <= wdata_d;
            ret_addr_q <= ret_addr_d;
            err_q      <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset drops them at once.
    assign bus.stk_push  = (state_q == StPush);
    assign bus.stk_pop   = (state_q == StPop);
    assign bus.stk_wdata = wdata_q;
    assign bus.ret_addr  = ret_addr_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.done      = (state_q == StDone);

endmodule

// File: tb/tb_stack_ctrl.sv
// Randomized bench for stack_ctrl: a small LIFO stands in for the stack, and a queue-based
// reference predicts strobes, latency, err and ret_addr for every request.
module tb_stack_ctrl;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    stack_ctrl_if #(.WIDTH(WIDTH)) bus ();

    stack_ctrl #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Environment stack: push/pop act on the rising edge, read data appears after the pop edge.
    logic [WIDTH-1:0] mem [DEPTH];
    int               stk_cnt = 0;

    always @(posedge clk) begin
        if (bus.stk_push && stk_cnt < DEPTH) begin
            mem[stk_cnt] <= bus.stk_wdata;
            stk_cnt      <= stk_cnt + 1;
        end else if (bus.stk_pop && stk_cnt > 0) begin
            bus.stk_rdata <= mem[stk_cnt-1];
            stk_cnt       <= stk_cnt - 1;
        end
    end

    assign bus.stk_empty = (stk_cnt == 0);
    assign bus.stk_full  = (stk_cnt == DEPTH);

    // Reference: what the stack should hold, last returned address, sticky error seen.
    logic [WIDTH-1:0] ref_q [$];
    logic [WIDTH-1:0] exp_ret     = '0;
    logic             sticky_seen = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (bus.stk_push || bus.stk_pop)
            check("strobe_excl", {31'd0, bus.stk_push & bus.stk_pop}, 32'd0);
    end

    function automatic logic idle_err_exp();
`ifdef STACK_CTRL_STICKY_ERR_EN
        return sticky_seen;
`else
        return 1'b0;
`endif
    endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge with it idle again.
    task automatic do_req(input logic c, input logic r, input logic [WIDTH-1:0] pc);
        logic             exp_err = 1'b0;
        int               exp_lat;
        int               exp_push = 0;
        int               exp_pop = 0;
        logic [WIDTH-1:0] exp_wd = pc + 8'd1;
        int               lat = 0;
        int               npush = 0;
        int               npop = 0;
        logic             got_err = 1'b0;
        logic [WIDTH-1:0] got_ra = '0;
        logic [WIDTH-1:0] got_wd = '0;

        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_err", {31'd0, bus.err}, {31'd0, idle_err_exp()});

        if (c && r) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (c) begin
            if (ref_q.size() == DEPTH) begin
                exp_err = 1'b1;
                exp_lat = 1;
            end else begin
                exp_push = 1;
                exp_lat  = 2;
            end
        end else begin
            if (ref_q.size() == 0) begin
                exp_err = 1'b1;
                exp_lat = 1;
            end else begin
                exp_pop = 1;
                exp_lat = 3;
            end
        end

        bus.call_req = c;
        bus.ret_req  = r;
        bus.pc_in    = pc;
        @(posedge clk);
        #1;
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;

        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk);
            if (bus.stk_push) begin
                npush++;
                got_wd = bus.stk_wdata;
            end
            if (bus.stk_pop) npop++;
            if (bus.done) begin
                lat     = k;
                got_err = bus.err;
                got_ra  = bus.ret_addr;
            end
        end

        if (exp_push != 0) ref_q.push_back(exp_wd);
        if (exp_pop != 0) exp_ret = ref_q.pop_back();
        if (exp_err) sticky_seen = 1'b1;

        check("done_latency", lat, exp_lat);
        check("push_count", npush, exp_push);
        check("pop_count", npop, exp_pop);
        check("err_at_done", {31'd0, got_err}, {31'd0, exp_err | idle_err_exp()});
        check("ret_addr", {24'd0, got_ra}, {24'd0, exp_ret});
        if (exp_push != 0) check("push_wdata", {24'd0, got_wd}, {24'd0, exp_wd});
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_push"}, {31'd0, bus.stk_push}, 32'd0);
        check({tag, "_pop"}, {31'd0, bus.stk_pop}, 32'd0);
        check({tag, "_wdata"}, {24'd0, bus.stk_wdata}, 32'd0);
        check({tag, "_ret_addr"}, {24'd0, bus.ret_addr}, 32'd0);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_done"}, {31'd0, bus.done}, 32'd0);
        check({tag, "_err"}, {31'd0, bus.err}, 32'd0);
    endtask

    initial begin
        int sel;
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;
        bus.pc_in    = '0;

        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed: basic call/return, underflow, wrap, overflow, conflict.
        do_req(1'b1, 1'b0, 8'h10);
        do_req(1'b0, 1'b1, 8'h00);
        do_req(1'b0, 1'b1, 8'h00);
        do_req(1'b1, 1'b0, 8'hFF);
        do_req(1'b1, 1'b0, 8'h20);
        do_req(1'b1, 1'b0, 8'h30);
        do_req(1'b1, 1'b0, 8'h40);
        do_req(1'b1, 1'b0, 8'h50);
        do_req(1'b1, 1'b1, 8'h60);
        for (int i = 0; i < 4; i++) do_req(1'b0, 1'b1, 8'h00);

        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 5)      do_req(1'b1, 1'b0, WIDTH'($urandom));
            else if (sel < 9) do_req(1'b0, 1'b1, WIDTH'($urandom));
            else              do_req(1'b1, 1'b1, WIDTH'($urandom));
        end

        // Reset in the middle of a pop: strobe must drop at once and nothing is popped.
        if (ref_q.size() == 0) do_req(1'b1, 1'b0, 8'h33);
        bus.ret_req = 1'b1;
        @(posedge clk);
        #1;
        bus.ret_req = 1'b0;
        check("pop_before_rst", {31'd0, bus.stk_pop}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_pop_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_ret     = '0;
        sticky_seen = 1'b0;
        @(negedge clk);
        check("stack_depth_kept", stk_cnt, ref_q.size());
        do_req(1'b1, 1'b0, 8'h42);
        do_req(1'b0, 1'b1, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, address/data width of return addresses and stack data.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: call_req  input  1  CPU request to save return address.
REQ-005 SHALL have port: ret_req  input  1  CPU request to restore return address.
REQ-006 SHALL have port: pc_in  input  WIDTH  current PC of the CALL instruction.
REQ-007 SHALL have port: ret_addr  output  WIDTH  last popped return address.
REQ-008 SHALL have port: busy  output  1  high while any state other than IDLE.
REQ-009 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-010 SHALL have port: err  output  1  overflow/underflow/conflict indication.
REQ-011 SHALL have port: stk_push  output  1  push strobe to stack.
REQ-012 SHALL have port: stk_pop  output  1  pop strobe to stack.
REQ-013 SHALL have port: stk_wdata  output  WIDTH  data to stack data_in.
REQ-014 SHALL have port: stk_rdata  input  WIDTH  stack data_out, valid the cycle after the pop edge.
REQ-015 SHALL have port: stk_empty  input  1  stack empty flag.
REQ-016 SHALL have port: stk_full  input  1  stack full flag.

Function
REQ-017 SHALL implement FSM states IDLE, PUSH, POP, WAIT, DONE.
REQ-018 SHALL sample call_req/ret_req only in IDLE; requests in other states are ignored, not queued.
REQ-019 IDLE + call_req only + !stk_full SHALL go to PUSH; stk_wdata = pc_in + 1 mod 2^WIDTH, registered at the sampling edge.
REQ-020 PUSH SHALL assert stk_push for exactly one cycle, then go to DONE.
REQ-021 IDLE + ret_req only + !stk_empty SHALL go to POP; POP asserts stk_pop for exactly one cycle, then WAIT.
REQ-022 WAIT SHALL capture stk_rdata into ret_addr, then go to DONE.
REQ-023 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-024 Latency: call sampled at edge N -> stk_push high in cycle N..N+1 -> done high in cycle N+1..N+2; ret adds one WAIT cycle (done one cycle later, ret_addr valid with done).
REQ-025 call_req with stk_full SHALL skip PUSH, go directly to DONE with err, no stk_push.
REQ-026 ret_req with stk_empty SHALL skip POP/WAIT, go directly to DONE with err, ret_addr unchanged.
REQ-027 call_req and ret_req both high in IDLE SHALL cause no stack operation; go to DONE with err.
REQ-028 stk_push and stk_pop SHALL never be high in the same cycle.
REQ-029 pc_in = 2^WIDTH-1 SHALL push 0 (wrap-around).

Reset
REQ-030 rst high SHALL immediately force IDLE, stk_push=0, stk_pop=0, stk_wdata=0, ret_addr=0, busy=0, done=0, err=0.
REQ-031 rst asserted mid-PUSH or mid-POP SHALL drop the strobe asynchronously; no partial operation is completed.

Configuration
REQ-032 Macro STACK_CTRL_STICKY_ERR_EN defined: err SHALL set with the failing DONE cycle and hold until rst.
REQ-033 Macro STACK_CTRL_STICKY_ERR_EN undefined: err SHALL be a one-cycle pulse coincident with done.

Verification
REQ-034 WIDTH=8, empty stack, call_req with pc_in=0x10 -> one stk_push with stk_wdata=0x11, done two cycles after request, err=0.
REQ-035 Then ret_req -> one stk_pop, done three cycles after request, ret_addr=0x11, err=0.
REQ-036 stk_empty=1, ret_req -> no stk_pop, done next cycle, err=1, ret_addr unchanged.
REQ-037 stk_full=1, call_req -> no stk_push, done next cycle, err=1.
REQ-038 call_req and ret_req together -> no strobes, err=1; pc_in=0xFF call -> stk_wdata=0x00.
REQ-039 rst pulsed during POP cycle -> stk_pop low immediately, all outputs at reset values, next call_req processed normally.
